ucq_arb: RTL and testbench
==========================

UCQ_ARB -- requirements
Module: ucq_arb

Interface
REQ-001 Parameter NUM_PE, default 4: number of BCP engines served.
REQ-002 Parameter UCQ_DEPTH, default 8, power of two: unit-clause queue entries.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  synchronous, active-high reset; the block is in reset when rst_n==1.
REQ-005 pe_imply_valid  in  NUM_PE  per-engine implication request; held until granted.
REQ-006 pe_imply_lit  in  lit_t[NUM_PE]  implied literal, signed 2's complement; 0 is reserved.
REQ-007 pe_conflict  in  NUM_PE  per-engine conflict indication.
REQ-008 pe_newLitAccept  in  NUM_PE  engine ready to consume the broadcast literal.
REQ-009 pe_imply_grant  out  NUM_PE  one-hot; the request is consumed this cycle.
REQ-010 ext_lit  in  lit_t  decision literal from the decision stage.
REQ-011 ext_valid  in  1  ext_lit is valid.
REQ-012 ext_ready  out  1  ext_lit is consumed when ext_valid && ext_ready.
REQ-013 newLit  out  lit_t  queue-head literal broadcast to all engines.
REQ-014 newLitValid  out  1  newLit is valid.
REQ-015 conflict_out  out  1  sticky conflict flag.
REQ-016 conflict_clr  in  1  clears conflict_out.
REQ-017 ucq_count  out  $clog2(UCQ_DEPTH)+1  number of occupied entries.

Function
REQ-018 Arbitration: round-robin over asserted pe_imply_valid, starting from the index after the last granted engine; at most one grant per cycle; the grant is combinational.
REQ-019 No grant is issued while the queue is full, while conflict_out==1, or in any cycle where any pe_conflict bit is 1.
REQ-020 A granted literal is pushed at the tail, except in these cases (each still granted):
- literal == 0: dropped.
- literal equals any valid entry: dropped as a duplicate.
- literal equals the negation of any valid entry: not pushed; sets conflict_out.
REQ-021 ext_ready = queue empty && !conflict_out && !(|pe_imply_valid); ext_lit is pushed under the same rules as REQ-020.
REQ-022 newLitValid = !empty && !conflict_out; newLit = head entry, or 0 when empty.
REQ-023 Pop rule: a registered accept mask ORs in pe_newLitAccept while newLitValid==1; the head pops in the cycle where (mask | pe_newLitAccept) is all-ones, and the mask clears that cycle.
REQ-024 A push and a pop in the same cycle are both performed; count is unchanged; a push is allowed when full only if a pop occurs in that cycle.
REQ-025 The duplicate and negation checks compare against the entries valid at the start of the cycle, including a head being popped that cycle.
REQ-026 Latency: a literal pushed into an empty queue appears on newLit/newLitValid the next cycle.
REQ-027 Pointers wrap modulo UCQ_DEPTH; ucq_count ranges from 0 to UCQ_DEPTH.
REQ-028 Any pe_conflict bit, or the REQ-020 negation case, on a cycle:
- sets conflict_out next cycle;
- flushes the queue (count=0, pointers=0);
- clears the accept mask.
REQ-029 conflict_clr==1 clears conflict_out next cycle; a new conflict in the same cycle wins and conflict_out stays 1.
REQ-030 Outputs not otherwise defined are 0.

Reset
REQ-031 On rst_n==1: pointers=0, ucq_count=0, accept mask=0, round-robin pointer=0 (engine 0 has priority), conflict_out=0.
REQ-032 During reset: newLitValid=0, newLit=0, pe_imply_grant=0, ext_ready=0.
REQ-033 Reset asserted mid-operation discards all queued literals within one cycle.

Verification
REQ-034 Reset, then ext_lit=+5 with ext_valid -> next cycle newLit=+5, newLitValid=1, ucq_count=1.
REQ-035 NUM_PE=4, head +5; accepts arrive on separate cycles in the order PE0, PE2, PE1, PE3 -> pops only on the PE3 cycle, and ucq_count decrements then.
REQ-036 All four engines request +3, -7, +3, +9 simultaneously -> grants go to 0,1,2,3 on consecutive cycles; queue holds +3, -7, +9; the duplicate +3 is dropped.
REQ-037 Queue holds +4; an engine implies -4 -> granted, conflict_out=1 next cycle, ucq_count=0, newLitValid=0; conflict_clr pulse -> conflict_out=0 next cycle.
REQ-038 Fill to UCQ_DEPTH=8 -> grants stop; a full accept pop in the same cycle as a pending request -> push and pop both occur, ucq_count stays 8, tail wraps to 0.
REQ-039 pe_conflict[2] is asserted in the same cycle as conflict_clr -> conflict_out remains 1 and the queue is flushed.

Source files
------------

// File: rtl/ucq_arb_if.sv
// Bundle between the BCP engines, the decision stage and the unit-clause queue arbiter.
// master drives requests/literals; slave is the arbiter.
interface ucq_arb_if #(
   parameter int unsigned NUM_PE    = 4,
   parameter int unsigned UCQ_DEPTH = 8,
   parameter int unsigned LIT_W     = 16
);
   localparam int unsigned CntW = $clog2(UCQ_DEPTH) + 1;

   logic [NUM_PE-1:0]             pe_imply_valid;
   logic [NUM_PE-1:0][LIT_W-1:0]  pe_imply_lit;
   logic [NUM_PE-1:0]             pe_conflict;
   logic [NUM_PE-1:0]             pe_newLitAccept;
   logic [NUM_PE-1:0]             pe_imply_grant;
   logic [LIT_W-1:0]              ext_lit;
   logic                          ext_valid;
   logic                          ext_ready;
   logic [LIT_W-1:0]              newLit;
   logic                          newLitValid;
   logic                          conflict_out;
   logic                          conflict_clr;
   logic [CntW-1:0]               ucq_count;

   modport master (
      output pe_imply_valid, pe_imply_lit, pe_conflict, pe_newLitAccept,
      output ext_lit, ext_valid, conflict_clr,
      input  pe_imply_grant, ext_ready, newLit, newLitValid, conflict_out, ucq_count
   );

   modport slave (
      input  pe_imply_valid, pe_imply_lit, pe_conflict, pe_newLitAccept,
      input  ext_lit, ext_valid, conflict_clr,
      output pe_imply_grant, ext_ready, newLit, newLitValid, conflict_out, ucq_count
   );
endinterface

// File: rtl/ucq_arb.sv
// Unit-clause queue: round-robin arbitration of engine implications, duplicate/negation
// filtering, head broadcast with all-engine accept, and sticky conflict handling.
module ucq_arb #(
   parameter int unsigned NUM_PE    = 4,
   parameter int unsigned UCQ_DEPTH = 8,
   parameter int unsigned LIT_W     = 16
) (
   input logic      clk,
   input logic      rst_n,
   ucq_arb_if.slave ucq
);
   localparam int unsigned PtrW = $clog2(UCQ_DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam int unsigned IdxW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

   logic [LIT_W-1:0]     mem_q [UCQ_DEPTH];
   logic [PtrW-1:0]      head_q, head_d, tail_q, tail_d;
   logic [CntW-1:0]      count_q, count_d;
   logic [NUM_PE-1:0]    mask_q, mask_d;
   logic [IdxW-1:0]      rr_q, rr_d;
   logic                 conflict_q, conflict_d;

   logic                 empty, full, lit_vld, pop, grant_en, gnt_any, ext_fire, push_req;
   logic [IdxW-1:0]      gnt_idx, cand;
   logic [NUM_PE-1:0]    grant;
   logic [LIT_W-1:0]     push_lit, neg_lit;
   logic [UCQ_DEPTH-1:0] ent_vld;
   logic [PtrW-1:0]      off;
   logic                 dup_hit, neg_hit, do_push, neg_conf, conflict_evt;

   // rst_n is active-high here: the block is held in reset while it is 1.
   assign empty    = (count_q == '0);
   assign full     = (count_q == CntW'(UCQ_DEPTH));
   assign lit_vld  = !rst_n && !empty && !conflict_q;
   assign pop      = lit_vld && (&(mask_q | ucq.pe_newLitAccept));
   assign grant_en = !rst_n && !conflict_q && !(|ucq.pe_conflict) && (!full || pop);
   assign ext_fire = ucq.ext_valid && ucq.ext_ready;

   assign ucq.ext_ready      = !rst_n && empty && !conflict_q && !(|ucq.pe_imply_valid);
   assign ucq.pe_imply_grant = grant;
   assign ucq.newLitValid    = lit_vld;
   assign ucq.newLit         = lit_vld ? mem_q[head_q] : '0;
   assign ucq.conflict_out   = conflict_q;
   assign ucq.ucq_count      = count_q;

   // Search starts at rr_q, the engine after the last one granted.
   always_comb begin
      grant   = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      cand    = '0;
      if (grant_en) begin
         for (int k = 0; k < int'(NUM_PE); k++) begin
            cand = IdxW'((32'(rr_q) + 32'(k)) % NUM_PE);
            if (!gnt_any && ucq.pe_imply_valid[cand]) begin
               gnt_any = 1'b1;
               gnt_idx = cand;
            end
         end
         if (gnt_any) grant[gnt_idx] = 1'b1;
      end
   end

   assign push_req = gnt_any || ext_fire;
   assign push_lit = gnt_any ? ucq.pe_imply_lit[gnt_idx] : ucq.ext_lit;
   assign neg_lit  = '0 - push_lit;

   // Filtering sees every entry valid at cycle start, including a head popped this cycle.
   always_comb begin
      ent_vld = '0;
      dup_hit = 1'b0;
      neg_hit = 1'b0;
      off     = '0;
      for (int i = 0; i < int'(UCQ_DEPTH); i++) begin
         off        = PtrW'(i) - head_q;
         ent_vld[i] = ({1'b0, off} < count_q);
         if (ent_vld[i] && (mem_q[i] == push_lit)) dup_hit = 1'b1;
         if (ent_vld[i] && (mem_q[i] == neg_lit)) neg_hit = 1'b1;
      end
   end

   assign do_push      = push_req && (push_lit != '0) && !dup_hit && !neg_hit;
   assign neg_conf     = push_req && (push_lit != '0) && !dup_hit && neg_hit;
   assign conflict_evt = (|ucq.pe_conflict) || neg_conf;

   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      mask_d     = mask_q;
      conflict_d = conflict_q;
      rr_d       = rr_q;
      if (gnt_any) begin
         rr_d = (gnt_idx == IdxW'(NUM_PE - 1)) ? '0 : gnt_idx + 1'b1;
      end
      if (conflict_evt) begin
         head_d     = '0;
         tail_d     = '0;
         count_d    = '0;
         mask_d     = '0;
         conflict_d = 1'b1;
      end else begin
         if (pop) head_d = head_q + 1'b1;
         if (do_push) tail_d = tail_q + 1'b1;
         unique case ({do_push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
         endcase
         if (pop) begin
            mask_d = '0;
         end else if (lit_vld) begin
            mask_d = mask_q | ucq.pe_newLitAccept;
         end
         if (ucq.conflict_clr) conflict_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         mask_q     <= '0;
         rr_q       <= '0;
         conflict_q <= 1'b0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         mask_q     <= mask_d;
         rr_q       <= rr_d;
         conflict_q <= conflict_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[tail_q] <= push_lit;
   end
endmodule

// File: tb/tb_ucq_arb.sv
// Directed table-driven bench for ucq_arb, plus a fill/wrap/drain sequence.
module tb_ucq_arb;
   localparam int NPE = 4;
   localparam int DEPTH = 8;
   localparam int LW = 16;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   ucq_arb_if #(.NUM_PE(NPE), .UCQ_DEPTH(DEPTH), .LIT_W(LW)) u_if ();

   ucq_arb #(.NUM_PE(NPE), .UCQ_DEPTH(DEPTH), .LIT_W(LW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ucq   (u_if)
   );

   typedef struct packed {
      logic            rst;
      logic [3:0]      v;
      logic [3:0][15:0] lits;
      logic [3:0]      conf;
      logic [3:0]      acc;
      logic [15:0]     ext;
      logic            ev;
      logic            clr;
      logic [3:0]      eg;
      logic            er;
      logic [15:0]     enl;
      logic            enlv;
      logic            eco;
      logic [3:0]      ecnt;
   } vec_t;

   vec_t vecs[$];
   int n_tests = 0;
   int n_fail = 0;

   task automatic add(input int rst, v, l0, l1, l2, l3, conf, acc, ext, ev, clr,
                      input int eg, er, enl, enlv, eco, ecnt);
      vec_t t;
      t.rst  = 1'(rst);
      t.v    = 4'(v);
      t.lits = {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
      t.conf = 4'(conf);
      t.acc  = 4'(acc);
      t.ext  = 16'(ext);
      t.ev   = 1'(ev);
      t.clr  = 1'(clr);
      t.eg   = 4'(eg);
      t.er   = 1'(er);
      t.enl  = 16'(enl);
      t.enlv = 1'(enlv);
      t.eco  = 1'(eco);
      t.ecnt = 4'(ecnt);
      vecs.push_back(t);
   endtask

   task automatic chk(input string nm, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %0h, expected %0h", nm, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      rst_n                   = t.rst;
      u_if.pe_imply_valid     = t.v;
      u_if.pe_imply_lit       = t.lits;
      u_if.pe_conflict        = t.conf;
      u_if.pe_newLitAccept    = t.acc;
      u_if.ext_lit            = t.ext;
      u_if.ext_valid          = t.ev;
      u_if.conflict_clr       = t.clr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   vec_t h;

   initial begin
      h = '0;
      h.rst = 1'b1;
      drive(h);

      // Expected values are the outputs seen before the clock edge that applies the row.
      //  rst v    l0  l1  l2  l3 conf acc ext ev clr | eg er nl nlv co cnt
      add(1, 'hF,  1,  2,  3,  4, 0, 0,  5, 1, 0,   0, 0, 0, 0, 0, 0);
      add(1, 'hF,  1,  2,  3,  4, 0, 0,  5, 1, 0,   0, 0, 0, 0, 0, 0);
      add(0, 0,    0,  0,  0,  0, 0, 0,  5, 1, 0,   0, 1, 0, 0, 0, 0);
      add(0, 0,    0,  0,  0,  0, 0, 0,  0, 0, 0,   0, 0, 5, 1, 0, 1);
      add(0, 0,    0,  0,  0,  0, 0, 1,  0, 0, 0,   0, 0, 5, 1, 0, 1);
      add(0, 0,    0,  0,  0,  0, 0, 4,  0, 0, 0,   0, 0, 5, 1, 0, 1);
      add(0, 0,    0,  0,  0,  0, 0, 2,  0, 0, 0,   0, 0, 5, 1, 0, 1);
      add(0, 0,    0,  0,  0,  0, 0, 8,  0, 0, 0,   0, 0, 5, 1, 0, 1);
      add(0, 0,    0,  0,  0,  0, 0, 0,  0, 0, 0,   0, 1, 0, 0, 0, 0);
      add(0, 'hF,  3, -7,  3,  9, 0, 0,  0, 0, 0,   1, 0, 0, 0, 0, 0);
      add(0, 'hE,  3, -7,  3,  9, 0, 0,  0, 0, 0,   2, 0, 3, 1, 0, 1);
      add(0, 'hC,  3, -7,  3,  9, 0, 0,  0, 0, 0,   4, 0, 3, 1, 0, 2);
      add(0, 'h8,  3, -7,  3,  9, 0, 0,  0, 0, 0,   8, 0, 3, 1, 0, 2);
      add(0, 0,    0,  0,  0,  0, 0, 0,  0, 0, 0,   0, 0, 3, 1, 0, 3);
      add(0, 0,    0,  0,  0,  0, 0, 15, 0, 0, 0,   0, 0, 3, 1, 0, 3);
      add(0, 0,    0,  0,  0,  0, 0, 15, 0, 0, 0,   0, 0, -7, 1, 0, 2);
      add(0, 0,    0,  0,  0,  0, 0, 15, 0, 0, 0,   0, 0, 9, 1, 0, 1);
      add(0, 0,    0,  0,  0,  0, 0, 0,  0, 0, 0,   0, 1, 0, 0, 0, 0);
      add(0, 0,    0,  0,  0,  0, 0, 0,  4, 1, 0,   0, 1, 0, 0, 0, 0);
      add(0, 1,   -4,  0,  0,  0, 0, 0,  0, 0, 0,   1, 0, 4, 1, 0, 1);
      add(0, 0,    0,  0,  0,  0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 1, 0);
      add(0, 2,    0,  6,  0,  0, 0, 0,  0, 0, 1,   0, 0, 0, 0, 1, 0);
      add(0, 2,    0,  6,  0,  0, 0, 0,  0, 0, 0,   2, 0, 0, 0, 0, 0);
      add(0, 0,    0,  0,  0,  0, 0, 0,  0, 0, 0,   0, 0, 6, 1, 0, 1);
      add(0, 0,    0,  0,  0,  0, 4, 0,  0, 0, 0,   0, 0, 6, 1, 0, 1);
      add(0, 0,    0,  0,  0,  0, 4, 0,  0, 0, 1,   0, 0, 0, 0, 1, 0);
      add(0, 0,    0,  0,  0,  0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 1, 0);
      add(0, 0,    0,  0,  0,  0, 0, 0,  0, 0, 1,   0, 0, 0, 0, 1, 0);
      add(0, 0,    0,  0,  0,  0, 0, 0,  0, 0, 0,   0, 1, 0, 0, 0, 0);
      add(0, 0,    0,  0,  0,  0, 0, 0, 21, 1, 0,   0, 1, 0, 0, 0, 0);
      add(1, 0,    0,  0,  0,  0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 1);
      add(0, 0,    0,  0,  0,  0, 0, 0,  0, 0, 0,   0, 1, 0, 0, 0, 0);

      tick();
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i]);
         #1;
         chk("grant",     i, 32'(u_if.pe_imply_grant), 32'(vecs[i].eg));
         chk("ext_ready", i, 32'(u_if.ext_ready),      32'(vecs[i].er));
         chk("newLit",    i, 32'(u_if.newLit),         32'(vecs[i].enl));
         chk("newLitVld", i, 32'(u_if.newLitValid),    32'(vecs[i].enlv));
         chk("conflict",  i, 32'(u_if.conflict_out),   32'(vecs[i].eco));
         chk("count",     i, 32'(u_if.ucq_count),      32'(vecs[i].ecnt));
         tick();
      end

      // Fill the queue from engine 0 with 10..17.
      h = '0;
      h.v = 4'b0001;
      for (int i = 0; i < DEPTH; i++) begin
         h.lits[0] = 16'(10 + i);
         drive(h);
         #1;
         chk("fill_grant", 100 + i, 32'(u_if.pe_imply_grant), 32'h1);
         chk("fill_count", 100 + i, 32'(u_if.ucq_count), 32'(i));
         tick();
      end

      // Full: a pending request is held off until a pop frees a slot.
      h.lits[0] = 16'd18;
      for (int i = 0; i < 2; i++) begin
         drive(h);
         #1;
         chk("full_grant", 200 + i, 32'(u_if.pe_imply_grant), 32'h0);
         chk("full_count", 200 + i, 32'(u_if.ucq_count), 32'd8);
         chk("full_head",  200 + i, 32'(u_if.newLit), 32'd10);
         tick();
      end
      h.acc = 4'hF;
      drive(h);
      #1;
      chk("pushpop_grant", 210, 32'(u_if.pe_imply_grant), 32'h1);
      tick();

      // Re-imply the head while it pops: dropped as a duplicate.
      h.lits[0] = 16'd11;
      drive(h);
      #1;
      chk("pushpop_count", 211, 32'(u_if.ucq_count), 32'd8);
      chk("pushpop_head",  211, 32'(u_if.newLit), 32'd11);
      chk("duphead_grant", 211, 32'(u_if.pe_imply_grant), 32'h1);
      tick();

      // Drain: 12..17 then the wrapped 18.
      h.v = 4'b0000;
      for (int k = 0; k < 7; k++) begin
         drive(h);
         #1;
         chk("drain_lit",   300 + k, 32'(u_if.newLit), 32'(12 + k));
         chk("drain_count", 300 + k, 32'(u_if.ucq_count), 32'(7 - k));
         tick();
      end
      h.acc = 4'h0;
      drive(h);
      #1;
      chk("drained_count", 310, 32'(u_if.ucq_count), 32'd0);
      chk("drained_valid", 310, 32'(u_if.newLitValid), 32'd0);
      chk("drained_ready", 310, 32'(u_if.ext_ready), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
